// File: rtl/data_cache.sv
// Direct-mapped, write-back / write-allocate data cache.
// 64 lines of one 32-bit word each; index = addr_i[7:2], tag = addr_i[31:8].
// Hits complete in the same cycle they are presented. A miss writes back a
// dirty victim first, then fills from backing memory, then re-evaluates
// as a hit.
module data_cache (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t      state_q;
  logic [63:0] valid_q;
  logic [63:0] dirty_q;
  logic [23:0] tag_q  [64];
  logic [31:0] data_q [64];

  logic [5:0]  idx;
  logic [23:0] tag;
  logic        req;
  logic        is_wr;
  logic        hit;
  logic        unused_addr_bits;

  assign idx              = addr_i[7:2];
  assign tag              = addr_i[31:8];
  assign req              = rd_i | wr_i;
  assign is_wr            = wr_i;
  assign unused_addr_bits = ^addr_i[1:0];

  // Hit detection against the indexed line
  always_comb begin
    hit = req && valid_q[idx] && (tag_q[idx] == tag);
  end

  // Controller state and per-line valid/dirty bits
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit && is_wr) begin
            dirty_q[idx] <= 1'b1;
          end else if (req && !hit) begin
            state_q <= (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          if (mem_ready_i) begin
            dirty_q[idx] <= 1'b0;
            state_q      <= FILL;
          end
        end
        FILL: begin
          if (mem_ready_i) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data and tag arrays; an async reset forces IDLE, so no update can
  // land from an aborted fill even though these arrays are not reset.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && hit && is_wr) begin
      data_q[idx] <= data_i;
    end else if (state_q == FILL && mem_ready_i) begin
      data_q[idx] <= mem_rdata_i;
      tag_q[idx]  <= tag;
    end
  end

  // Requester and backing-memory outputs decoded from the state register
  always_comb begin
    valid_o     = 1'b0;
    data_o      = '0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      IDLE: begin
        valid_o = !req || hit;
        if (hit && !is_wr) begin
          data_o = data_q[idx];
        end
      end
      WRITEBACK: begin
        mem_wr_o    = 1'b1;
        mem_addr_o  = {tag_q[idx], idx, 2'b00};
        mem_wdata_o = data_q[idx];
      end
      FILL: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = {addr_i[31:2], 2'b00};
      end
      default: ;
    endcase
  end

endmodule
